// File: rtl/fastica_pkg.sv
// Shared constants and types for the FastICA datapath blocks.
// Q2.14 weights multiply into Q4.28 products, which accumulate in Q(ACC_W-28).28.
package fastica_pkg;

  localparam int          FRAC_W       = 14;
  localparam int          ACC_FRAC     = 2 * FRAC_W;
  localparam logic [63:0] ONE_Q28      = 64'd1 << ACC_FRAC;
  localparam logic [39:0] EPS_DEF      = 40'd268435;
  localparam logic [7:0]  MAX_ITER_DEF = 8'd100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_ROW_EVAL,
    ST_FINAL,
    ST_DONE
  } err_state_e;

endpackage

// File: rtl/fastica_error_calc_if.sv
// Weight-memory read port shared by the FastICA stages.
// rd_new/rd_old are sampled on the clock edge that closes the rd_en cycle.
interface fastica_error_calc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_new;
  logic signed [DATA_W-1:0] rd_old;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_new,
    input  rd_old
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_new,
    output rd_old
  );

endinterface

// File: rtl/fastica_dot_mac.sv
// Three-stage signed dot-product engine: operand register, full-precision
// product, sign-extended accumulate. Reused by the norm and orthogonalisation stages.
module fastica_dot_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic                     op_valid;
  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

  // NOTE: sequential state uses non-blocking assignments so each stage sees the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_valid   <= 1'b0;
      prod_q     <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      op_valid <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      prod_valid <= op_valid;
      prod_q     <= a_q * b_q;
      // Inputs arriving outside a valid read are never summed.
      if (clr) begin
        acc <= '0;
      end else if (prod_valid) begin
        acc <= acc + prod_ext;
      end
    end
  end

endmodule

// File: rtl/fastica_error_calc.sv
// FastICA convergence checker: max over rows of |1 - |<w_new, w_old>|| against EPS.
// error_busy=1 tells the loop controller to run another iteration.
module fastica_error_calc
  import fastica_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              VEC_N    = 4,
  parameter int              ROW_N    = 4,
  parameter int              ACC_W    = 40,
  parameter logic [ACC_W-1:0] EPS     = ACC_W'(EPS_DEF),
  parameter logic [7:0]      MAX_ITER = MAX_ITER_DEF
) (
  input  logic                 clk_error,
  input  logic                 rst,
  input  logic                 en_error,
  input  logic                 clr_iter,
  fastica_error_calc_if.master rd_bus,
  output logic                 calc_busy,
  output logic                 done,
  output logic                 error_busy,
  output logic                 max_iter_hit,
  output logic [ACC_W-1:0]     max_err,
  output logic [7:0]           iter_cnt
);

  localparam int COL_W = (VEC_N > 1) ? $clog2(VEC_N) : 1;
  localparam int ROW_W = (ROW_N > 1) ? $clog2(ROW_N) : 1;
  localparam logic [COL_W-1:0]       COL_LAST = COL_W'(VEC_N - 1);
  localparam logic [ROW_W-1:0]       ROW_LAST = ROW_W'(ROW_N - 1);
  localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(ONE_Q28);

  err_state_e              state;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic                    drain_2nd;
  logic [ACC_W-1:0]        max_err_work;

  logic                    mac_clr;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] absd;
  logic signed [ACC_W-1:0] diff;
  logic [ACC_W-1:0]        row_err;
  logic                    conv;
  logic                    force_hit;

  // Accumulator restarts at job start and after each row has been evaluated.
  assign mac_clr = ((state == ST_IDLE) && en_error) || (state == ST_ROW_EVAL);

  fastica_dot_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk_error),
    .rst      (rst),
    .in_valid (rd_bus.rd_en),
    .clr      (mac_clr),
    .a        (rd_bus.rd_new),
    .b        (rd_bus.rd_old),
    .acc      (acc)
  );

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    absd      = acc[ACC_W-1] ? -acc : acc;
    diff      = ONE - absd;
    row_err   = diff[ACC_W-1] ? $unsigned(-diff) : $unsigned(diff);
    conv      = (max_err_work <= EPS);
    force_hit = !conv && (iter_cnt == MAX_ITER - 8'd1);
  end

  always_ff @(posedge clk_error) begin
    if (rst) begin
      state          <= ST_IDLE;
      rd_bus.rd_en   <= 1'b0;
      rd_bus.rd_addr <= '0;
      col            <= '0;
      row            <= '0;
      drain_2nd      <= 1'b0;
      calc_busy      <= 1'b0;
      done           <= 1'b0;
      error_busy     <= 1'b1;
      max_iter_hit   <= 1'b0;
      max_err        <= '0;
      max_err_work   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_error) begin
            max_err_work   <= '0;
            calc_busy      <= 1'b1;
            rd_bus.rd_en   <= 1'b1;
            rd_bus.rd_addr <= '0;
            col            <= '0;
            row            <= '0;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (col == COL_LAST) begin
            rd_bus.rd_en <= 1'b0;
            col          <= '0;
            drain_2nd    <= 1'b0;
            state        <= ST_DRAIN;
          end else begin
            col            <= col + 1'b1;
            rd_bus.rd_addr <= rd_bus.rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Two cycles: the last product lands, then the last accumulate.
          drain_2nd <= 1'b1;
          if (drain_2nd) begin
            state <= ST_ROW_EVAL;
          end
        end
        ST_ROW_EVAL: begin
          if (row_err > max_err_work) begin
            max_err_work <= row_err;
          end
          if (row == ROW_LAST) begin
            state <= ST_FINAL;
          end else begin
            row            <= row + 1'b1;
            rd_bus.rd_addr <= rd_bus.rd_addr + 1'b1;
            rd_bus.rd_en   <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_FINAL: begin
          error_busy   <= !(conv || force_hit);
          max_iter_hit <= force_hit;
          max_err      <= max_err_work;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          done      <= 1'b1;
          calc_busy <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A clear landing in FINAL wins; the force decision above still saw the old count.
  always_ff @(posedge clk_error) begin
    if (rst || clr_iter) begin
      iter_cnt <= '0;
    end else if ((state == ST_FINAL) && (iter_cnt != 8'hFF)) begin
      iter_cnt <= iter_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fastica_error_calc.sv
// Scoreboard bench for fastica_error_calc: directed cases plus randomized matrices,
// with expected results from a plain-arithmetic reference model.
module tb_fastica_error_calc;

  localparam int          DATA_W   = 16;
  localparam int          VEC_N    = 4;
  localparam int          ROW_N    = 4;
  localparam int          ACC_W    = 40;
  localparam int          ADDR_W   = 4;
  localparam int          N_EL     = ROW_N * VEC_N;
  localparam logic [7:0]  MAX_ITER = 8'd3;
  localparam longint      EPS      = 268435;
  localparam longint      ONE      = 268435456;
  localparam int          LATENCY  = ROW_N * (VEC_N + 3) + 2;

  typedef struct {
    longint      max_err;
    logic        error_busy;
    logic        max_iter_hit;
    logic [7:0]  iter_cnt;
    int unsigned due;
  } exp_t;

  logic             clk_error = 1'b0;
  logic             rst;
  logic             en_error;
  logic             clr_iter;
  logic             calc_busy;
  logic             done;
  logic             error_busy;
  logic             max_iter_hit;
  logic [ACC_W-1:0] max_err;
  logic [7:0]       iter_cnt;

  logic signed [DATA_W-1:0] w_new [N_EL];
  logic signed [DATA_W-1:0] w_old [N_EL];

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          model_iter = 0;
  int unsigned cyc = 0;

  fastica_error_calc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rd_bus ();

  fastica_error_calc #(
    .DATA_W   (DATA_W),
    .VEC_N    (VEC_N),
    .ROW_N    (ROW_N),
    .ACC_W    (ACC_W),
    .EPS      (40'd268435),
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk_error    (clk_error),
    .rst          (rst),
    .en_error     (en_error),
    .clr_iter     (clr_iter),
    .rd_bus       (rd_bus.master),
    .calc_busy    (calc_busy),
    .done         (done),
    .error_busy   (error_busy),
    .max_iter_hit (max_iter_hit),
    .max_err      (max_err),
    .iter_cnt     (iter_cnt)
  );

  always #5 clk_error = ~clk_error;

  always @(posedge clk_error) cyc <= cyc + 1;

  // Weight memory; junk outside a read so stray accumulation shows up.
  always_comb begin
    rd_bus.rd_new = rd_bus.rd_en ? w_new[rd_bus.rd_addr] : 16'sh7fff;
    rd_bus.rd_old = rd_bus.rd_en ? w_old[rd_bus.rd_addr] : 16'sh7fff;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint abs_l(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint model_max_err();
    longint m;
    longint d;
    m = 0;
    for (int r = 0; r < ROW_N; r++) begin
      d = 0;
      for (int c = 0; c < VEC_N; c++)
        d += longint'(w_new[r*VEC_N + c]) * longint'(w_old[r*VEC_N + c]);
      if (abs_l(ONE - abs_l(d)) > m) m = abs_l(ONE - abs_l(d));
    end
    return m;
  endfunction

  task automatic load_identity(input int sign);
    for (int i = 0; i < N_EL; i++) begin
      w_old[i] = ((i / VEC_N) == (i % VEC_N)) ? 16'sh4000 : 16'sh0000;
      w_new[i] = (sign < 0) ? -w_old[i] : w_old[i];
    end
  endtask

  // Predicts the outcome, pulses en_error, returns just after the sampling edge.
  task automatic start_eval(input bit clr_at_final);
    exp_t   x;
    longint m;
    bit     conv;
    bit     frc;
    m    = model_max_err();
    conv = (m <= EPS);
    frc  = !conv && (model_iter == int'(MAX_ITER) - 1);
    x.max_err      = m;
    x.error_busy   = !(conv || frc);
    x.max_iter_hit = frc;
    if (clr_at_final) model_iter = 0;
    else if (model_iter < 255) model_iter++;
    x.iter_cnt = 8'(model_iter);
    @(negedge clk_error);
    en_error = 1'b1;
    x.due = cyc + 1 + LATENCY;
    sb_q.push_back(x);
    @(negedge clk_error);
    en_error = 1'b0;
    check("busy_after_start", calc_busy, 1);
    check("rd_en_after_start", rd_bus.rd_en, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk_error);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 64'(sb_q.size()), 0);
      sb_q.delete();
    end
    @(negedge clk_error);
  endtask

  task automatic do_clr();
    @(negedge clk_error);
    clr_iter = 1'b1;
    @(negedge clk_error);
    clr_iter = 1'b0;
    model_iter = 0;
    check("clr_iter_cnt", iter_cnt, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, rd_bus.rd_en, 0);
    check({tag, "_rd_addr"}, rd_bus.rd_addr, 0);
    check({tag, "_calc_busy"}, calc_busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error_busy"}, error_busy, 1);
    check({tag, "_max_iter_hit"}, max_iter_hit, 0);
    check({tag, "_max_err"}, max_err, 0);
    check({tag, "_iter_cnt"}, iter_cnt, 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_error);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          x = sb_q.pop_front();
          check("done_latency", cyc, x.due);
          check("max_err", max_err, x.max_err);
          check("error_busy", error_busy, x.error_busy);
          check("max_iter_hit", max_iter_hit, x.max_iter_hit);
          check("iter_cnt", iter_cnt, x.iter_cnt);
          check("busy_low_at_done", calc_busy, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    int v;
    rst      = 1'b1;
    en_error = 1'b0;
    clr_iter = 1'b0;
    load_identity(1);
    repeat (3) @(negedge clk_error);
    rst = 1'b0;
    @(negedge clk_error);
    check_reset_values("reset");

    // Identity, negated identity, one orthogonal row.
    start_eval(1'b0);
    wait_done();
    check("identity_max_err", max_err, 0);
    check("identity_error_busy", error_busy, 0);

    load_identity(-1);
    start_eval(1'b0);
    wait_done();
    check("neg_identity_error_busy", error_busy, 0);

    do_clr();
    load_identity(1);
    w_new[2*VEC_N + 2] = 16'sh0000;
    w_new[2*VEC_N + 3] = 16'sh4000;
    start_eval(1'b0);
    wait_done();
    check("orth_row_max_err", max_err, 64'h0010000000);
    check("orth_row_error_busy", error_busy, 1);

    // Iteration limit: row 0 at half scale never converges on its own.
    do_clr();
    load_identity(1);
    w_new[0] = 16'sh2000;
    for (int run = 0; run < 3; run++) begin
      start_eval(1'b0);
      wait_done();
    end
    check("limit_max_err", max_err, 64'h0008000000);
    check("limit_forced_hit", max_iter_hit, 1);
    do_clr();

    // Clear landing on the FINAL cycle: force uses the old count, count ends at 0.
    start_eval(1'b0);
    wait_done();
    start_eval(1'b0);
    wait_done();
    start_eval(1'b1);
    repeat (28) @(negedge clk_error);
    clr_iter = 1'b1;
    @(negedge clk_error);
    clr_iter = 1'b0;
    wait_done();

    // Threshold boundary: e == EPS converges, e == EPS+1 does not.
    do_clr();
    load_identity(1);
    w_new[1*VEC_N + 1] = 16'sd185;
    w_old[1*VEC_N + 1] = -16'sd1451;
    w_new[1*VEC_N + 0] = 16'sh4000;
    w_old[1*VEC_N + 0] = 16'sh4000;
    w_new[1*VEC_N + 2] = 16'sh0000;
    w_old[1*VEC_N + 2] = 16'sh0000;
    start_eval(1'b0);
    wait_done();
    check("eps_exact_max_err", max_err, 64'(EPS));
    check("eps_exact_error_busy", error_busy, 0);
    w_new[1*VEC_N + 2] = 16'sd1;
    w_old[1*VEC_N + 2] = -16'sd1;
    start_eval(1'b0);
    wait_done();
    check("eps_plus1_max_err", max_err, 64'(EPS + 1));
    check("eps_plus1_error_busy", error_busy, 1);

    // Reset mid-evaluation aborts with no partial result.
    load_identity(1);
    start_eval(1'b0);
    repeat (11) @(negedge clk_error);
    rst = 1'b1;
    @(negedge clk_error);
    sb_q.delete();
    model_iter = 0;
    check_reset_values("abort");
    rst = 1'b0;

    // Fresh start after abort, with an en_error pulse mid-run that must be ignored.
    start_eval(1'b0);
    repeat (5) @(negedge clk_error);
    en_error = 1'b1;
    @(negedge clk_error);
    en_error = 1'b0;
    wait_done();
    repeat (40) @(negedge clk_error);

    // Randomized: near +/-identity with small perturbations, or arbitrary matrices.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) do_clr();
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < N_EL; i++) begin
        if (mode == 2) begin
          w_old[i] = 16'($urandom);
          w_new[i] = 16'($urandom);
        end else begin
          w_old[i] = ((i / VEC_N) == (i % VEC_N)) ? 16'sh4000 : 16'sh0000;
          if ((i / VEC_N) == (i % VEC_N)) begin
            v = 16384 + int'($urandom_range(0, 48)) - 24;
            if (mode == 1) v = -v;
          end else begin
            v = int'($urandom_range(0, 16)) - 8;
          end
          w_new[i] = 16'(v);
        end
      end
      start_eval(1'b0);
      wait_done();
    end

    repeat (5) @(negedge clk_error);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fastica_error_calc.md
Name: fastica_error_calc

Overview:
- Convergence checker for the FastICA iteration loop. Runs after the fixed-point update stage and before the loop re-enters symmetric orthogonalisation.
- Reads the updated unmixing matrix W_new and the previous W_old row by row from the weight memory. For each row it computes the dot product d = <w_new, w_old>.
- It then reports whether max over rows of |1 - |d|| <= EPS. The result drives error_busy, which the top-level controller samples to decide between another iteration and output.

Parameters:
- DATA_W, 16, weight element width, signed Q2.14.
- VEC_N, 4, elements per weight row.
- ROW_N, 4, rows of W (number of sources).
- ACC_W, 40, accumulator width, signed Q(ACC_W-28).28.
- EPS, 40'd268435 (~1e-3 in Q.28), convergence threshold, same scale as accumulator.
- MAX_ITER, 8'd100, evaluations before forced convergence.

Ports:
- clk_error  in  1  block clock.
- rst  in  1  synchronous active-high reset.
- en_error  in  1  start request, sampled only in IDLE.
- clr_iter  in  1  clears iteration counter (new separation job), sampled any state.
- rd_en  out  1  weight memory read strobe.
- rd_addr  out  $clog2(ROW_N*VEC_N)  element address = row*VEC_N + col.
- rd_new  in  DATA_W  W_new element, valid 1 cycle after rd_en.
- rd_old  in  DATA_W  W_old element, valid 1 cycle after rd_en.
- calc_busy  out  1  high while an evaluation is in progress.
- done  out  1  one-cycle pulse when result is updated.
- error_busy  out  1  1 = not converged (iterate again), 0 = converged.
- max_iter_hit  out  1  convergence was forced by the iteration limit.
- max_err  out  ACC_W  largest |1-|d|| of last evaluation.
- iter_cnt  out  8  completed evaluations since rst/clr_iter.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, calc_busy=0, done=0, error_busy=1, max_iter_hit=0, max_err=0, iter_cnt=0, state=IDLE.
- Reset mid-operation aborts immediately to the reset values. There are no partial results.
- States: IDLE, ISSUE, DRAIN, ROW_EVAL, FINAL, DONE.
- IDLE:
  - On en_error=1: clear max_err_work and acc, set calc_busy=1, go to ISSUE.
  - en_error during any other state is ignored.
- ISSUE:
  - rd_en=1 for VEC_N consecutive cycles. rd_addr = row*VEC_N + col, col counting 0..VEC_N-1.
  - Pipeline: the data cycle registers rd_new and rd_old; the next cycle registers the full-precision product (2*DATA_W, Q4.28) sign-extended to ACC_W; the next cycle accumulates.
  - After the last col, go to DRAIN.
- DRAIN: 2 cycles to empty the product and accumulate stages, then go to ROW_EVAL.
- ROW_EVAL (1 cycle):
  - absd = |acc|; e = |ONE - absd| with ONE = 1<<28.
  - If e > max_err_work, then max_err_work = e.
  - Clear acc. If row < ROW_N-1: row++, go to ISSUE. Else go to FINAL.
- FINAL:
  - conv = (max_err_work <= EPS). force = !conv && (iter_cnt == MAX_ITER-1).
  - Update: error_busy = !(conv|force); max_iter_hit = force; max_err = max_err_work.
  - iter_cnt saturates at 255. Go to DONE.
- DONE: done=1 for one cycle, calc_busy=0, go to IDLE.
- Timing:
  - Latency from the en_error sample to the done pulse is ROW_N*(VEC_N+3)+2 cycles (30 at defaults).
  - error_busy, max_err and max_iter_hit hold stable until the next FINAL.
  - The controller must wait for done, or for calc_busy to fall, before sampling error_busy.
- Arithmetic:
  - Signed two's complement throughout; no saturation is needed because ACC_W covers VEC_N products.
  - d = -1.0 counts as converged (sign ambiguity is inherent to ICA).
  - Exactly e == EPS counts as converged.
- Simultaneous clr_iter with FINAL: clear wins (iter_cnt=0 after). The force decision uses the pre-clear value.
- clr_iter does not affect error_busy.

Decomposition:
- Shared package fastica_pkg holds:
  - Q-format constants (FRAC_W=14, ACC_FRAC=28, ONE_Q28).
  - Default EPS.
  - State enum localparams.
- One natural sub-module: fastica_dot_mac. It covers the registered operand stage, the multiply stage, the accumulate stage, and a clear input. It is reusable by the norm/orth stages.
- The FSM, the max-tracking logic and the iteration counter stay in the top.

Test Plan:
- W_new = W_old = identity (diagonal 0x4000), en_error pulse -> done exactly 30 cycles later, max_err=0, error_busy=0, max_iter_hit=0, iter_cnt=1.
- W_new = -W_old (diagonal 0xC000) -> d=-1.0 per row, max_err=0, error_busy=0.
- Row 2 of W_new orthogonal to W_old row 2 (0x4000 moved to another column), other rows identical -> max_err=ONE=0x0010000000, error_busy=1.
- MAX_ITER=3, W_new row 0 = 0.5*W_old row 0 (0x2000 vs 0x4000) for every run:
  - runs 1 and 2 -> error_busy=1, max_err=0x0008000000;
  - run 3 -> error_busy=0, max_iter_hit=1, iter_cnt=3;
  - clr_iter -> iter_cnt=0.
- Boundary: choose data giving e = EPS exactly -> error_busy=0; change to e = EPS+1 -> error_busy=1.
- Assert rst at cycle 12 of an evaluation -> next cycle all outputs at reset values (error_busy=1, calc_busy=0). A fresh en_error then completes normally in 30 cycles. An en_error pulse while calc_busy=1 is ignored (single done pulse).
